interrupt_controller: RTL

Interrupt source side of the jump/interrupt protocol. It detects rising edges on external interrupt lines and latches them as pending requests. It arbitrates among unmasked requests and drives a single-cycle `interrupt` pulse into the jump control unit, which then vectors the PC to 16'hF000 and saves the return address and flags. It blocks further interrupts until the handler's RET is decoded, and it never fires while a jump-class instruction is in decode.

---
 rtl/jump_pkg.sv | 27 ++
 rtl/irq_prio_enc.sv | 20 ++
 rtl/interrupt_controller.sv | 75 +++++++
 3 files changed

// File: rtl/jump_pkg.sv
// Shared definitions for the jump/interrupt protocol: opcodes, vector address, interrupt FSM states.
package jump_pkg;

  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_JV  = 6'b011100;
  localparam logic [5:0] OP_JNV = 6'b011101;
  localparam logic [5:0] OP_JZ  = 6'b011110;
  localparam logic [5:0] OP_JNZ = 6'b011111;
  localparam logic [5:0] OP_RET = 6'b010000;

  localparam logic [15:0] INT_VECTOR = 16'hF000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIRE    = 3'd1,
    VEC     = 3'd2,
    FLG     = 3'd3,
    SERVICE = 3'd4
  } irq_state_t;

  // An interrupt must not be injected while any of these is in decode.
  function automatic logic is_jump(input logic [5:0] op);
    return (op == OP_JMP) || (op == OP_JV) || (op == OP_JNV) ||
           (op == OP_JZ)  || (op == OP_JNZ) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan high to low so the lowest set index is written last.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-detects interrupt lines, latches pending requests and issues one interrupt pulse at a time,
// holding off while a jump-class opcode is in decode and until the handler's RET.
module interrupt_controller
  import jump_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic [5:0]         op_dec,
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  irq_state_t         state, state_nxt;
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] src_edge;
  logic [NUM_SRC-1:0] clr;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic               fire_go;

  assign src_edge = irq_src & ~src_d;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req   (pending & irq_mask),
    .valid (win_valid),
    .id    (win_id)
  );

  // The winner is taken on the edge entering FIRE, so irq_id and the cleared
  // pending bit are already visible while the interrupt pulse is high.
  assign fire_go = (state == IDLE) && win_valid && !is_jump(op_dec);
  assign clr     = fire_go ? (NUM_SRC'(1) << win_id) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire_go) state_nxt = FIRE;
      FIRE:    state_nxt = VEC;
      VEC:     state_nxt = FLG;
      FLG:     state_nxt = SERVICE;
      SERVICE: if (op_dec == OP_RET) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      src_d      <= '0;
      pending    <= '0;
      irq_id     <= '0;
      interrupt  <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state      <= state_nxt;
      src_d      <= irq_src;
      // A new edge on the bit being acknowledged keeps it pending.
      pending    <= (pending & ~clr) | src_edge;
      if (fire_go) irq_id <= win_id;
      interrupt  <= (state_nxt == FIRE);
      in_service <= (state_nxt != IDLE);
    end
  end

endmodule
